// File: rtl/bip_debug_unit_if.sv
// Bus between bip_debug_unit and its environment (UART FIFOs and the BIP core).
// Compile-time option: BIP_DBG_CHECKSUM_EN (consumed by bip_debug_unit only).
//
// Signals:
//   rx_data   : head byte of the UART RX FIFO, valid whenever rx_empty=0
//   rx_empty  : RX FIFO empty
//   rd_uart   : pop RX FIFO head this cycle
//   tx_data   : byte to the UART TX FIFO
//   wr_uart   : push tx_data into the TX FIFO this cycle
//   tx_full   : TX FIFO full
//   bip_halt  : processor decoded HALT (level)
//   acc_in    : current accumulator value
//   pc_in     : current program counter
//   start_bip : processor run enable
// Modports: master = debug unit side, slave = UART/processor side.
interface bip_debug_unit_if #(
  parameter int unsigned AB = 11,
  parameter int unsigned DB = 16
) ();
  logic [7:0]    rx_data;
  logic          rx_empty;
  logic          rd_uart;
  logic [7:0]    tx_data;
  logic          wr_uart;
  logic          tx_full;
  logic          bip_halt;
  logic [DB-1:0] acc_in;
  logic [AB-1:0] pc_in;
  logic          start_bip;

  modport master (
    input  rx_data, rx_empty, tx_full, bip_halt, acc_in, pc_in,
    output rd_uart, tx_data, wr_uart, start_bip
  );

  modport slave (
    output rx_data, rx_empty, tx_full, bip_halt, acc_in, pc_in,
    input  rd_uart, tx_data, wr_uart, start_bip
  );
endinterface

// File: rtl/bip_debug_unit.sv
// Debug sequencer between the UART and the BIP processor. Waits for a start
// command byte on the RX FIFO, runs the processor while counting its cycles,
// and on HALT streams {acc, pc, cycle count} as a byte frame (MSB byte first
// per field, each field zero-extended to whole bytes) into the TX FIFO.
//
// Optional feature macro: BIP_DBG_CHECKSUM_EN -- when defined, one extra byte
// holding the XOR of all frame bytes is appended to the frame.
//
// Ports:
//   i_clk   : system clock
//   i_reset : synchronous, active-high reset
//   io_dbg  : bip_debug_unit_if.master (UART FIFO handshakes, BIP control/state)
//   o_busy  : high while running the processor or sending the frame
module bip_debug_unit #(
  parameter int unsigned AB         = 11,
  parameter int unsigned DB         = 16,
  parameter int unsigned CW         = 16,
  parameter logic [7:0]  START_BYTE = 8'h53
) (
  input  logic               i_clk,
  input  logic               i_reset,
  bip_debug_unit_if.master   io_dbg,
  output logic               o_busy
);

  localparam int unsigned NA = (DB + 7) / 8;
  localparam int unsigned NP = (AB + 7) / 8;
  localparam int unsigned NC = (CW + 7) / 8;
  localparam int unsigned N  = NA + NP + NC;
`ifdef BIP_DBG_CHECKSUM_EN
  localparam int unsigned LEN = N + 1;
`else
  localparam int unsigned LEN = N;
`endif
  localparam int unsigned IW = $clog2(LEN + 1);

  typedef enum logic [1:0] {StIdle, StRun, StSend} state_e;

  state_e        r_state, w_state_next;
  logic [CW-1:0] r_cnt;
  logic [DB-1:0] r_acc;
  logic [AB-1:0] r_pc;
  logic [IW-1:0] r_idx;

  logic [NA*8-1:0] w_acc_ext;
  logic [NP*8-1:0] w_pc_ext;
  logic [NC*8-1:0] w_cnt_ext;
  logic [N*8-1:0]  w_frame;
  logic [7:0]      w_sel;
  logic            w_rd, w_wr, w_start, w_busy;
  logic [7:0]      w_tx;

  always_comb begin
    w_acc_ext = '0;
    w_pc_ext  = '0;
    w_cnt_ext = '0;
    w_acc_ext[DB-1:0] = r_acc;
    w_pc_ext[AB-1:0]  = r_pc;
    w_cnt_ext[CW-1:0] = r_cnt;
  end

  // Byte 0 of the frame sits in the top byte of w_frame.
  assign w_frame = {w_acc_ext, w_pc_ext, w_cnt_ext};

`ifdef BIP_DBG_CHECKSUM_EN
  logic [7:0] w_csum;
  always_comb begin
    w_csum = '0;
    for (int unsigned k = 0; k < N; k++) begin
      w_csum = w_csum ^ w_frame[k*8 +: 8];
    end
  end
`endif

  always_comb begin
    w_sel = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (r_idx == IW'(k)) w_sel = w_frame[(N-1-k)*8 +: 8];
    end
`ifdef BIP_DBG_CHECKSUM_EN
    if (r_idx == IW'(N)) w_sel = w_csum;
`endif
  end

  always_comb begin
    w_state_next = r_state;
    w_rd         = 1'b0;
    w_wr         = 1'b0;
    w_start      = 1'b0;
    w_busy       = 1'b0;
    w_tx         = 8'h00;
    case (r_state)
      StIdle: begin
        // Every byte is consumed; only the start command leaves IDLE.
        w_rd = !io_dbg.rx_empty;
        if (!io_dbg.rx_empty && io_dbg.rx_data == START_BYTE) w_state_next = StRun;
      end
      StRun: begin
        w_start = 1'b1;
        w_busy  = 1'b1;
        if (io_dbg.bip_halt) w_state_next = StSend;
      end
      StSend: begin
        w_busy = 1'b1;
        w_tx   = w_sel;
        w_wr   = !io_dbg.tx_full;
        if (w_wr && r_idx == IW'(LEN - 1)) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_pc    <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        StIdle: begin
          if (w_state_next == StRun) r_cnt <= '0;
        end
        StRun: begin
          if (io_dbg.bip_halt) begin
            // Counter is frozen from here on and doubles as the frame field.
            r_acc <= io_dbg.acc_in;
            r_pc  <= io_dbg.pc_in;
            r_idx <= '0;
          end else if (r_cnt != '1) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        StSend: begin
          if (w_wr) r_idx <= r_idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign io_dbg.rd_uart   = w_rd;
  assign io_dbg.wr_uart   = w_wr;
  assign io_dbg.tx_data   = w_tx;
  assign io_dbg.start_bip = w_start;
  assign o_busy           = w_busy;

endmodule

// File: tb/tb_bip_debug_unit.sv
// Self-checking bench for bip_debug_unit. Two instances (CW=16 and CW=4) see
// the same stimulus; sel chooses which one is checked. Expected frames are
// built from the field values, the run length and the field widths.
module tb_bip_debug_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_empty, tx_full, bip_halt;
  logic [15:0] acc;
  logic [10:0] pc;
  logic        busy_a, busy_b;
  logic        sel;

  bip_debug_unit_if #(.AB(11), .DB(16)) if_a ();
  bip_debug_unit_if #(.AB(11), .DB(16)) if_b ();

  assign if_a.rx_data  = rx_data;
  assign if_a.rx_empty = rx_empty;
  assign if_a.tx_full  = tx_full;
  assign if_a.bip_halt = bip_halt;
  assign if_a.acc_in   = acc;
  assign if_a.pc_in    = pc;
  assign if_b.rx_data  = rx_data;
  assign if_b.rx_empty = rx_empty;
  assign if_b.tx_full  = tx_full;
  assign if_b.bip_halt = bip_halt;
  assign if_b.acc_in   = acc;
  assign if_b.pc_in    = pc;

  bip_debug_unit #(.AB(11), .DB(16), .CW(16), .START_BYTE(8'h53)) u_dut_a (
    .i_clk   (clk),
    .i_reset (reset),
    .io_dbg  (if_a.master),
    .o_busy  (busy_a)
  );

  bip_debug_unit #(.AB(11), .DB(16), .CW(4), .START_BYTE(8'h53)) u_dut_b (
    .i_clk   (clk),
    .i_reset (reset),
    .io_dbg  (if_b.master),
    .o_busy  (busy_b)
  );

  logic       rd, wr, start, busy;
  logic [7:0] tx;
  always_comb begin
    if (sel) begin
      rd = if_b.rd_uart; wr = if_b.wr_uart; start = if_b.start_bip;
      busy = busy_b; tx = if_b.tx_data;
    end else begin
      rd = if_a.rd_uart; wr = if_a.wr_uart; start = if_a.start_bip;
      busy = busy_a; tx = if_a.tx_data;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
  endtask

  function automatic void push_field(input longint unsigned v, input int w);
    int nb = (w + 7) / 8;
    for (int k = nb - 1; k >= 0; k--) exp_q.push_back(8'((v >> (8 * k)) & 64'hFF));
  endfunction

  function automatic void build_frame(input logic [15:0] a, input logic [10:0] p,
                                      input int run_len, input int cw);
    longint unsigned cmax = (64'd1 << cw) - 1;
    longint unsigned cnt  = (longint'(run_len) > cmax) ? cmax : longint'(run_len);
    exp_q.delete();
    push_field(a, 16);
    push_field(p, 11);
    push_field(cnt, cw);
`ifdef BIP_DBG_CHECKSUM_EN
    begin
      logic [7:0] x = 8'h00;
      foreach (exp_q[i]) x ^= exp_q[i];
      exp_q.push_back(x);
    end
`endif
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; rx_empty = 1'b1; tx_full = 1'b0; bip_halt = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_start", start, 0);
    check_eq("rst_wr", wr, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rd", rd, 0);
    check_eq("rst_tx", tx, 0);
  endtask

  // Presents one byte in IDLE; it must be popped on this cycle.
  task automatic pop_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b; rx_empty = 1'b0; bip_halt = 1'($urandom);
    #1;
    check_eq("idle_rd", rd, 1);
    check_eq("idle_start", start, 0);
  endtask

  task automatic junk_byte();
    logic [7:0] b = 8'($urandom);
    if (b == 8'h53) b = 8'h54;
    pop_byte(b);
    @(negedge clk);
    rx_empty = 1'b1; bip_halt = 1'b0;
    #1;
    check_eq("junk_no_start", start, 0);
    check_eq("junk_no_busy", busy, 0);
  endtask

  // Called right after pop_byte(8'h53). stall: 0 none, 1 random, 2 five
  // cycles at byte index 2. abort_at >= 0 applies reset at that byte index.
  task automatic run_frame(input int run_len, input logic [15:0] a, input logic [10:0] p,
                           input int stall, input int abort_at);
    int idx = 0, cyc = 0, stalls = 0;
    build_frame(a, p, run_len, sel ? 4 : 16);
    for (int i = 0; i <= run_len; i++) begin
      @(negedge clk);
      rx_empty = 1'b0; rx_data = 8'h53;  // queued command must not be popped
      bip_halt = (i == run_len);
      acc = (i == run_len) ? a : 16'($urandom);
      pc  = (i == run_len) ? p : 11'($urandom);
      tx_full = 1'($urandom);
      #1;
      check_eq("run_start", start, 1);
      check_eq("run_busy", busy, 1);
      check_eq("run_rd", rd, 0);
      check_eq("run_wr", wr, 0);
    end
    while (idx < exp_q.size() && cyc < 200) begin
      @(negedge clk);
      bip_halt = 1'($urandom); acc = 16'($urandom); pc = 11'($urandom);
      case (stall)
        1:       tx_full = ($urandom_range(0, 2) == 0);
        2:       tx_full = (idx == 2 && stalls < 5);
        default: tx_full = 1'b0;
      endcase
      if (tx_full) stalls++;
      if (idx == abort_at) begin
        reset = 1'b1; tx_full = 1'b0;
        @(negedge clk);
        reset = 1'b0; rx_empty = 1'b1; bip_halt = 1'b0;
        #1;
        check_eq("abort_wr", wr, 0);
        check_eq("abort_start", start, 0);
        check_eq("abort_busy", busy, 0);
        return;
      end
      #1;
      check_eq("send_start", start, 0);
      check_eq("send_busy", busy, 1);
      check_eq("send_rd", rd, 0);
      check_eq("send_wr", wr, !tx_full);
      check_eq("send_byte", tx, exp_q[idx]);
      if (!tx_full) idx++;
      cyc++;
    end
    check_eq("send_len", idx, exp_q.size());
    @(negedge clk);
    rx_empty = 1'b1; bip_halt = 1'b0; tx_full = 1'b0;
    #1;
    check_eq("end_busy", busy, 0);
    check_eq("end_start", start, 0);
    check_eq("end_wr", wr, 0);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1; rx_data = 8'h00; rx_empty = 1'b1;
    tx_full = 1'b0; bip_halt = 1'b0; acc = '0; pc = '0;
    do_reset();

    pop_byte(8'h53);
    run_frame(20, 16'hBEEF, 11'h12A, 0, -1);

    pop_byte(8'h41); @(negedge clk); rx_empty = 1'b1; #1;
    check_eq("cmd41_start", start, 0);
    pop_byte(8'h00); @(negedge clk); rx_empty = 1'b1; #1;
    check_eq("cmd00_start", start, 0);
    pop_byte(8'h53);
    run_frame(int'($urandom_range(1, 30)), 16'($urandom), 11'($urandom), 1, -1);

    pop_byte(8'h53);
    run_frame(20, 16'hBEEF, 11'h12A, 2, -1);

    pop_byte(8'h53);
    run_frame(0, 16'($urandom), 11'($urandom), 0, -1);

    pop_byte(8'h53);
    run_frame(10, 16'h1234, 11'h321, 0, 3);
    pop_byte(8'h53);
    run_frame(7, 16'($urandom), 11'($urandom), 1, -1);

    for (int r = 0; r < 10; r++) begin
      if ($urandom_range(0, 1) == 1) junk_byte();
      pop_byte(8'h53);
      run_frame(int'($urandom_range(0, 60)), 16'($urandom), 11'($urandom), 1, -1);
    end

    sel = 1'b1;
    do_reset();
    pop_byte(8'h53);
    run_frame(40, 16'hBEEF, 11'h12A, 0, -1);
    for (int r = 0; r < 3; r++) begin
      pop_byte(8'h53);
      run_frame(int'($urandom_range(0, 30)), 16'($urandom), 11'($urandom), 1, -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
